// File: rtl/imem_ctrl_pkg.sv
// Shared types and AHB-Lite encodings for the instruction-ROM AHB slave.
// IMEM_CTRL_WAIT_EN adds the WAIT state used by the registered-address build.
package imem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RDATA = 3'd1,
        ST_ERR1  = 3'd2,
`ifdef IMEM_CTRL_WAIT_EN
        ST_ERR2  = 3'd3,
        ST_WAIT  = 3'd4
`else
        ST_ERR2  = 3'd3
`endif
    } imem_ctrl_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // {HREADYOUT, HRESP} presented while the FSM sits in a given state
    function automatic logic [1:0] resp_of_state(input imem_ctrl_state_t st);
        logic [1:0] r;
        case (st)
            ST_IDLE:  r = {1'b1, HRESP_OKAY};
            ST_RDATA: r = {1'b1, HRESP_OKAY};
            ST_ERR1:  r = {1'b0, HRESP_ERROR};
            ST_ERR2:  r = {1'b1, HRESP_ERROR};
`ifdef IMEM_CTRL_WAIT_EN
            ST_WAIT:  r = {1'b0, HRESP_OKAY};
`endif
            default:  r = {1'b1, HRESP_OKAY};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_ahb_decode.sv
// Combinational classification of an AHB-Lite address phase into good ROM read or error.
module imem_ahb_decode
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 256,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000
) (
    input  logic        hsel,
    input  logic        hready,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    output logic        good_rd,
    output logic        err,
    output logic [31:0] offset
);

    // 33 bits so a window ending at the top of the address map cannot wrap
    localparam logic [32:0] ROM_BYTES = 33'(ROM_DEPTH) << 2;

    logic accept_s;
    logic in_range_s;

    // Transfer acceptance, window check and final classification
    always_comb begin
        offset     = haddr - ROM_BASE;
        in_range_s = (haddr >= ROM_BASE) && ({1'b0, offset} < ROM_BYTES);
        accept_s   = hsel && hready &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        good_rd    = accept_s && !hwrite && (hsize == HSIZE_WORD) &&
                     (haddr[1:0] == 2'b00) && in_range_s;
        err        = accept_s && !good_rd;
    end

endmodule

// File: rtl/imem_ahb_ctrl.sv
// AHB-Lite slave front-end for the instruction ROM: zero-wait reads, two-cycle ERROR.
// Defining IMEM_CTRL_WAIT_EN registers the address phase and adds one wait state per read.
module imem_ahb_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 256,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL1,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        rd_en_rom,
    output logic [31:0] address_rom,
    input  logic [31:0] instruction
);

    imem_ctrl_state_t state_q, state_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;
    logic [31:0]      addr_q, addr_d;

    logic             good_s;
    logic             err_s;
    logic [31:0]      offset_s;
    logic             open_s;
    logic             take_good_s;

    imem_ahb_decode #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_BASE  (ROM_BASE)
    ) u_decode (
        .hsel    (HSEL1),
        .hready  (HREADY),
        .htrans  (HTRANS),
        .hwrite  (HWRITE),
        .hsize   (HSIZE),
        .haddr   (HADDR),
        .good_rd (good_s),
        .err     (err_s),
        .offset  (offset_s)
    );

    // New transfers are only taken in states that drive HREADYOUT high
    always_comb begin
`ifdef IMEM_CTRL_WAIT_EN
        open_s = (state_q != ST_ERR1) && (state_q != ST_WAIT);
`else
        open_s = (state_q != ST_ERR1);
`endif
        take_good_s = good_s && open_s;
    end

    // Next-state, next-response and captured ROM address
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
`ifdef IMEM_CTRL_WAIT_EN
            ST_WAIT: state_d = ST_RDATA;
`endif
            default: begin
                if (take_good_s) begin
`ifdef IMEM_CTRL_WAIT_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_RDATA;
`endif
                end else if (err_s && open_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (take_good_s) begin
            addr_d = offset_s;
        end else begin
            addr_d = addr_q;
        end
        {hreadyout_d, hresp_d} = resp_of_state(state_d);
    end

    // FSM and response registers; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            addr_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            addr_q      <= addr_d;
        end
    end

    // ROM strobe: address phase in the zero-wait build, WAIT state otherwise
    always_comb begin
`ifdef IMEM_CTRL_WAIT_EN
        rd_en_rom   = (state_q == ST_WAIT) && !reset;
        address_rom = addr_q;
`else
        rd_en_rom = take_good_s && !reset;
        if (rd_en_rom) begin
            address_rom = offset_s;
        end else begin
            address_rom = addr_q;
        end
`endif
    end

    // ROM data is only exposed while a read data phase is in progress
    always_comb begin
        if (state_q == ST_RDATA) begin
            HRDATA = instruction;
        end else begin
            HRDATA = 32'h0000_0000;
        end
        HREADYOUT = hreadyout_q;
        HRESP     = hresp_q;
    end

endmodule
